// File: rtl/uart_pkg.sv
// Shared definitions for the configurable UART transmitter.
//   tx_state_e    : transmitter FSM states
//   PAR_*         : parity mode encodings for the PARITY parameter
//   calc_bps_cnt  : clock cycles per serial bit (integer division)
package uart_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_PARITY,
    ST_STOP
  } tx_state_e;

  localparam int PAR_NONE = 0;
  localparam int PAR_ODD  = 1;
  localparam int PAR_EVEN = 2;

  function automatic int calc_bps_cnt(input int clk_freq, input int uart_bps);
    return clk_freq / uart_bps;
  endfunction

endpackage

// File: rtl/uart_tx_cfg_if.sv
// Valid/ready byte stream into the UART transmitter.
//   tx_data  : word to send, sampled only on a handshake
//   tx_valid : source has a word on tx_data
//   tx_ready : transmitter holding register is empty
// A transfer happens on a clock edge where tx_valid and tx_ready are both high.
interface uart_tx_cfg_if #(
  parameter int DATA_BITS = 8
);
  logic [DATA_BITS-1:0] tx_data;
  logic                 tx_valid;
  logic                 tx_ready;

  modport master (output tx_data, output tx_valid, input tx_ready);
  modport slave  (input tx_data, input tx_valid, output tx_ready);
endinterface

// File: rtl/uart_baud_gen.sv
// Baud counter for the UART transmitter.
//   sys_clk  : clock
//   sys_rst  : synchronous active-high reset
//   restart  : force the counter back to 0 on the next edge
//   bit_tick : high in the last clock cycle of each serial bit
module uart_baud_gen #(
  parameter int BPS_CNT = 10
) (
  input  logic sys_clk,
  input  logic sys_rst,
  input  logic restart,
  output logic bit_tick
);

  localparam int              CNT_W   = (BPS_CNT > 1) ? $clog2(BPS_CNT) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(BPS_CNT - 1);

  logic [CNT_W-1:0] baud_cnt;

  // NOTE: clocked state is always written with <= so every flop samples the
  // pre-edge value of its neighbours, independent of statement order.
  always_ff @(posedge sys_clk) begin
    if (sys_rst || restart) begin
      baud_cnt <= '0;
    end else if (baud_cnt == CNT_MAX) begin
      baud_cnt <= '0;
    end else begin
      baud_cnt <= baud_cnt + CNT_W'(1);
    end
  end

  assign bit_tick = (baud_cnt == CNT_MAX);

endmodule

// File: rtl/uart_tx_cfg.sv
// Configurable UART transmitter with a one-entry holding register.
//   sys_clk  : clock
//   sys_rst  : synchronous active-high reset; aborts any frame in flight
//   tx_if    : valid/ready byte input (slave side)
//   uart_txd : registered serial line, idle high
//   tx_busy  : high while a frame is on the line (start through final stop)
//   tx_done  : one-cycle pulse in the last cycle of the final stop bit
// Frame: start(0), DATA_BITS data LSB first, optional parity, STOP_BITS stop(1).
// All line-side outputs are registered from the FSM state, so they trail the
// state by one cycle; a handshake at edge N puts the start bit on the line at N+2.
module uart_tx_cfg
  import uart_pkg::*;
#(
  parameter int CLK_FREQ  = 50000000,
  parameter int UART_BPS  = 9600,
  parameter int DATA_BITS = 8,
  parameter int PARITY    = 0,
  parameter int STOP_BITS = 1
) (
  input  logic         sys_clk,
  input  logic         sys_rst,
  uart_tx_cfg_if.slave tx_if,
  output logic         uart_txd,
  output logic         tx_busy,
  output logic         tx_done
);

  localparam int BPS_CNT = calc_bps_cnt(CLK_FREQ, UART_BPS);

  if (DATA_BITS < 5 || DATA_BITS > 9) begin : g_bad_data_bits
    $error("uart_tx_cfg: DATA_BITS must be in 5..9");
  end
  if (PARITY < PAR_NONE || PARITY > PAR_EVEN) begin : g_bad_parity
    $error("uart_tx_cfg: PARITY must be 0, 1 or 2");
  end
  if (STOP_BITS != 1 && STOP_BITS != 2) begin : g_bad_stop_bits
    $error("uart_tx_cfg: STOP_BITS must be 1 or 2");
  end
  if (BPS_CNT < 2) begin : g_bad_bps_cnt
    $error("uart_tx_cfg: CLK_FREQ / UART_BPS must be at least 2");
  end

  localparam logic [3:0] LAST_DATA = 4'(DATA_BITS - 1);
  localparam logic [3:0] LAST_STOP = 4'(STOP_BITS - 1);

  tx_state_e            state, next_state;
  logic                 hold_full;
  logic [DATA_BITS-1:0] hold_data;
  logic [DATA_BITS-1:0] shift_reg;
  logic                 par_bit;
  logic                 par_calc;
  logic [3:0]           bit_cnt;
  logic                 bit_tick;
  logic                 handshake;
  logic                 load;
  logic                 frame_end;
  logic                 restart;

  assign tx_if.tx_ready = ~hold_full;
  assign handshake      = tx_if.tx_valid & ~hold_full;
  assign frame_end      = (state == ST_STOP) && bit_tick && (bit_cnt == LAST_STOP);
  assign par_calc       = (PARITY == PAR_ODD) ? ~(^hold_data) : ^hold_data;

  // The counter is parked at 0 while idle and cleared again whenever a new
  // frame is loaded, so each START begins a fresh bit period.
  assign restart = load || (state == ST_IDLE);

  uart_baud_gen #(
    .BPS_CNT (BPS_CNT)
  ) u_baud_gen (
    .sys_clk  (sys_clk),
    .sys_rst  (sys_rst),
    .restart  (restart),
    .bit_tick (bit_tick)
  );

  // NOTE: every signal driven here gets a default first, so no path through
  // the case statement leaves it unassigned and no latch is inferred.
  always_comb begin
    next_state = state;
    load       = 1'b0;
    case (state)
      ST_IDLE: begin
        if (hold_full) begin
          next_state = ST_START;
          load       = 1'b1;
        end
      end
      ST_START: begin
        if (bit_tick) next_state = ST_DATA;
      end
      ST_DATA: begin
        if (bit_tick && bit_cnt == LAST_DATA) begin
          next_state = (PARITY == PAR_NONE) ? ST_STOP : ST_PARITY;
        end
      end
      ST_PARITY: begin
        if (bit_tick) next_state = ST_STOP;
      end
      ST_STOP: begin
        // A buffered word chains straight into the next start bit.
        if (frame_end) begin
          if (hold_full) begin
            next_state = ST_START;
            load       = 1'b1;
          end else begin
            next_state = ST_IDLE;
          end
        end
      end
      default: next_state = ST_IDLE;
    endcase
  end

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      state     <= ST_IDLE;
      hold_full <= 1'b0;
      bit_cnt   <= '0;
      uart_txd  <= 1'b1;
      tx_busy   <= 1'b0;
      tx_done   <= 1'b0;
    end else begin
      state <= next_state;

      if (handshake) begin
        hold_full <= 1'b1;
      end else if (load) begin
        hold_full <= 1'b0;
      end

      if (bit_tick && (state == ST_DATA || state == ST_STOP)) begin
        if ((state == ST_DATA && bit_cnt == LAST_DATA) ||
            (state == ST_STOP && bit_cnt == LAST_STOP)) begin
          bit_cnt <= '0;
        end else begin
          bit_cnt <= bit_cnt + 4'd1;
        end
      end

      tx_busy <= (state != ST_IDLE);
      tx_done <= frame_end;

      case (state)
        ST_START:  uart_txd <= 1'b0;
        ST_DATA:   uart_txd <= shift_reg[0];
        ST_PARITY: uart_txd <= par_bit;
        default:   uart_txd <= 1'b1;
      endcase
    end
  end

  // NOTE: pure datapath registers carry no reset; their contents are only
  // consumed once hold_full or the FSM says they are valid.
  always_ff @(posedge sys_clk) begin
    if (handshake) begin
      hold_data <= tx_if.tx_data;
    end
    if (load) begin
      shift_reg <= hold_data;
      par_bit   <= par_calc;
    end else if (state == ST_DATA && bit_tick) begin
      shift_reg <= shift_reg >> 1;
    end
  end

endmodule

// File: tb/tb_uart_tx_cfg.sv
// Self-checking bench for uart_tx_cfg. Four instances run side by side:
//   0: 8N1   1: 7 data, even parity, 1 stop   2: 7 data, odd parity   3: 8N2
// All use CLK_FREQ=1000, UART_BPS=100 (10 cycles per bit). A reference model
// tracks each instance as a one-entry buffer plus a timeline of frames; the
// expected line level for any cycle is looked up from the frame bit list.
module tb_uart_tx_cfg;

  localparam int BPS = 10;

  int cfg_bits [4] = '{8, 7, 7, 8};
  int cfg_par  [4] = '{0, 2, 1, 0};
  int cfg_stop [4] = '{1, 1, 1, 2};

  logic       sys_clk;
  logic       sys_rst;
  logic [3:0] vld;
  logic [8:0] dat [4];
  logic [3:0] txd, busy, done, rdy;

  int n_total = 0;
  int n_bad   = 0;
  int cyc     = 0;

  // Reference model state.
  bit          m_full    [4];
  logic [8:0]  m_hold    [4];
  bit          m_acc     [4];
  int          m_acc_cyc [4];
  bit          fr_act    [4][2];
  int          fr_s      [4][2];
  int          fr_len    [4][2];
  logic [15:0] fr_b      [4][2];
  bit          hs, xfer;
  logic        el, eb, ed;

  initial sys_clk = 1'b0;
  always #5 sys_clk = ~sys_clk;

  uart_tx_cfg_if #(.DATA_BITS(8)) if0 ();
  uart_tx_cfg_if #(.DATA_BITS(7)) if1 ();
  uart_tx_cfg_if #(.DATA_BITS(7)) if2 ();
  uart_tx_cfg_if #(.DATA_BITS(8)) if3 ();

  assign if0.tx_valid = vld[0];  assign if0.tx_data = dat[0][7:0];  assign rdy[0] = if0.tx_ready;
  assign if1.tx_valid = vld[1];  assign if1.tx_data = dat[1][6:0];  assign rdy[1] = if1.tx_ready;
  assign if2.tx_valid = vld[2];  assign if2.tx_data = dat[2][6:0];  assign rdy[2] = if2.tx_ready;
  assign if3.tx_valid = vld[3];  assign if3.tx_data = dat[3][7:0];  assign rdy[3] = if3.tx_ready;

  uart_tx_cfg #(.CLK_FREQ(1000), .UART_BPS(100), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1)) dut0 (
    .sys_clk(sys_clk), .sys_rst(sys_rst), .tx_if(if0),
    .uart_txd(txd[0]), .tx_busy(busy[0]), .tx_done(done[0]));
  uart_tx_cfg #(.CLK_FREQ(1000), .UART_BPS(100), .DATA_BITS(7), .PARITY(2), .STOP_BITS(1)) dut1 (
    .sys_clk(sys_clk), .sys_rst(sys_rst), .tx_if(if1),
    .uart_txd(txd[1]), .tx_busy(busy[1]), .tx_done(done[1]));
  uart_tx_cfg #(.CLK_FREQ(1000), .UART_BPS(100), .DATA_BITS(7), .PARITY(1), .STOP_BITS(1)) dut2 (
    .sys_clk(sys_clk), .sys_rst(sys_rst), .tx_if(if2),
    .uart_txd(txd[2]), .tx_busy(busy[2]), .tx_done(done[2]));
  uart_tx_cfg #(.CLK_FREQ(1000), .UART_BPS(100), .DATA_BITS(8), .PARITY(0), .STOP_BITS(2)) dut3 (
    .sys_clk(sys_clk), .sys_rst(sys_rst), .tx_if(if3),
    .uart_txd(txd[3]), .tx_busy(busy[3]), .tx_done(done[3]));

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Line bits of one frame, index 0 = start bit; unused upper bits stay 1.
  function automatic logic [15:0] frame_bits(input int i, input logic [8:0] d);
    logic [15:0] b;
    int k;
    int ones;
    b = '1;
    b[0] = 1'b0;
    k = 1;
    ones = 0;
    for (int j = 0; j < cfg_bits[i]; j++) begin
      b[k] = d[j];
      if (d[j]) ones++;
      k++;
    end
    if (cfg_par[i] == 1)      b[k] = (ones % 2 == 0);
    else if (cfg_par[i] == 2) b[k] = (ones % 2 == 1);
    return b;
  endfunction

  function automatic int frame_len(input int i);
    return (1 + cfg_bits[i] + ((cfg_par[i] != 0) ? 1 : 0) + cfg_stop[i]) * BPS;
  endfunction

  function automatic void expect_out(input int i, input int t,
                                     output logic line, output logic bsy, output logic dn);
    line = 1'b1;
    bsy  = 1'b0;
    dn   = 1'b0;
    for (int f = 0; f < 2; f++) begin
      if (fr_act[i][f] && t >= fr_s[i][f] && t < fr_s[i][f] + fr_len[i][f]) begin
        bsy  = 1'b1;
        line = fr_b[i][f][(t - fr_s[i][f]) / BPS];
        dn   = (t == fr_s[i][f] + fr_len[i][f] - 1);
      end
    end
  endfunction

  function automatic bit model_busy();
    for (int i = 0; i < 4; i++) begin
      if (m_full[i]) return 1'b1;
      if (fr_act[i][0] && fr_s[i][0] + fr_len[i][0] - 1 >= cyc) return 1'b1;
    end
    return 1'b0;
  endfunction

  // Model update: a buffered word starts its frame on the cycle after the
  // line becomes free, and the buffer empties at that same edge.
  always @(posedge sys_clk) begin
    cyc = cyc + 1;
    for (int i = 0; i < 4; i++) begin
      m_acc[i] = 1'b0;
      if (sys_rst) begin
        m_full[i]    = 1'b0;
        fr_act[i][0] = 1'b0;
        fr_act[i][1] = 1'b0;
      end else begin
        xfer = m_full[i] && (!fr_act[i][0] || fr_s[i][0] + fr_len[i][0] - 1 <= cyc);
        hs   = vld[i] && !m_full[i];
        if (xfer) begin
          fr_act[i][1] = fr_act[i][0];
          fr_s[i][1]   = fr_s[i][0];
          fr_len[i][1] = fr_len[i][0];
          fr_b[i][1]   = fr_b[i][0];
          fr_act[i][0] = 1'b1;
          fr_s[i][0]   = cyc + 1;
          fr_len[i][0] = frame_len(i);
          fr_b[i][0]   = frame_bits(i, m_hold[i]);
        end
        if (hs) begin
          m_hold[i]    = dat[i];
          m_full[i]    = 1'b1;
          m_acc[i]     = 1'b1;
          m_acc_cyc[i] = cyc;
        end else if (xfer) begin
          m_full[i] = 1'b0;
        end
      end
    end
  end

  // Cycle-by-cycle comparison of every output against the model.
  always @(negedge sys_clk) begin
    for (int i = 0; i < 4; i++) begin
      expect_out(i, cyc, el, eb, ed);
      check($sformatf("d%0d_txd@%0d", i, cyc),   32'(txd[i]),  32'(el));
      check($sformatf("d%0d_busy@%0d", i, cyc),  32'(busy[i]), 32'(eb));
      check($sformatf("d%0d_done@%0d", i, cyc),  32'(done[i]), 32'(ed));
      check($sformatf("d%0d_ready@%0d", i, cyc), 32'(rdy[i]),  32'(!m_full[i]));
    end
  end

  task automatic send(input int i, input logic [8:0] d, input bit drop);
    int n;
    n = 0;
    vld[i] = 1'b1;
    dat[i] = d;
    do begin
      @(negedge sys_clk);
      n++;
    end while (!m_acc[i] && n < 400);
    check($sformatf("d%0d_accept", i), 32'(m_acc[i]), 32'd1);
    if (drop) vld[i] = 1'b0;
    dat[i] = 9'($urandom);
  endtask

  task automatic wait_quiet();
    int n;
    n = 0;
    while (model_busy() && n < 2000) begin
      @(negedge sys_clk);
      n++;
    end
    check("quiet_timeout", 32'(n < 2000), 32'd1);
    repeat (3) @(negedge sys_clk);
  endtask

  initial begin
    int n, n1, n2, n3, first_done, second_done, gaps, b2b_txd, bad_cnt;
    int k;
    logic [15:0] cap [4];
    int done_at [4];
    int first_low [4];
    bit got_all;

    sys_rst = 1'b1;
    vld     = '0;
    for (int i = 0; i < 4; i++) dat[i] = 9'($urandom);
    repeat (3) @(negedge sys_clk);
    check("rst_txd",   32'(txd),  32'hF);
    check("rst_ready", 32'(rdy),  32'hF);
    check("rst_busy",  32'(busy), 32'h0);
    check("rst_done",  32'(done), 32'h0);
    sys_rst = 1'b0;
    repeat (3) @(negedge sys_clk);

    // Directed frames on all four configurations at once.
    vld    = 4'hF;
    dat[0] = 9'h0A5;
    dat[1] = 9'h055;
    dat[2] = 9'h055;
    dat[3] = 9'h081;
    n = 0;
    got_all = 1'b0;
    while (!got_all && n < 50) begin
      @(negedge sys_clk);
      n++;
      got_all = 1'b1;
      for (int i = 0; i < 4; i++) begin
        if (m_acc[i]) begin
          vld[i] = 1'b0;
          dat[i] = 9'($urandom);
        end
        if (vld[i]) got_all = 1'b0;
      end
    end
    check("directed_accept", 32'(got_all), 32'd1);
    n1 = m_acc_cyc[0];
    for (int i = 0; i < 4; i++) begin
      cap[i] = '1;
      done_at[i] = -1;
      first_low[i] = -1;
    end
    while (cyc < n1 + 2 + 110 + 5) begin
      @(negedge sys_clk);
      for (int i = 0; i < 4; i++) begin
        k = cyc - (n1 + 2);
        if (k >= 0 && k % 10 == 5 && k / 10 < 16) cap[i][k / 10] = txd[i];
        if (done[i] && done_at[i] < 0) done_at[i] = cyc;
        if (!txd[i] && first_low[i] < 0) first_low[i] = cyc;
      end
    end
    check("a5_8n1_bits",   32'(cap[0][9:0]),  32'(10'b1101001010));
    check("55_7e1_bits",   32'(cap[1][9:0]),  32'(10'b1010101010));
    check("55_7o1_bits",   32'(cap[2][9:0]),  32'(10'b1110101010));
    check("81_8n2_bits",   32'(cap[3][10:0]), 32'(11'b11100000010));
    check("a5_start_lat",  32'(first_low[0]), 32'(n1 + 2));
    check("a5_done_cyc",   32'(done_at[0]),   32'(n1 + 101));
    check("7e1_done_cyc",  32'(done_at[1]),   32'(n1 + 101));
    check("7o1_done_cyc",  32'(done_at[2]),   32'(n1 + 101));
    check("8n2_done_cyc",  32'(done_at[3]),   32'(n1 + 111));
    wait_quiet();

    // Back-to-back: second byte accepted mid-frame, zero gap on the line.
    send(0, 9'h000, 1'b1);
    n1 = m_acc_cyc[0];
    send(0, 9'h0FF, 1'b1);
    first_done = -1;
    second_done = -1;
    gaps = 0;
    b2b_txd = 1;
    n = 0;
    while (second_done < 0 && n < 400) begin
      @(negedge sys_clk);
      n++;
      if (!busy[0]) gaps++;
      if (done[0]) begin
        if (first_done < 0) first_done = cyc;
        else second_done = cyc;
      end
      if (first_done >= 0 && cyc == first_done + 1) b2b_txd = int'(txd[0]);
    end
    check("b2b_busy_gaps",   32'(gaps),        32'd0);
    check("b2b_next_start",  32'(b2b_txd),     32'd0);
    check("b2b_first_done",  32'(first_done),  32'(n1 + 101));
    check("b2b_second_done", 32'(second_done), 32'(first_done + 100));
    wait_quiet();

    // Buffer full: valid held across three words.
    send(0, 9'($urandom), 1'b0);
    n1 = m_acc_cyc[0];
    send(0, 9'($urandom), 1'b0);
    n2 = m_acc_cyc[0];
    send(0, 9'($urandom), 1'b1);
    n3 = m_acc_cyc[0];
    check("full_second_acc", 32'(n2), 32'(n1 + 2));
    check("full_third_acc",  32'(n3), 32'(n1 + 102));
    wait_quiet();

    // Reset during data bit 3 of 0x3C with another word buffered.
    send(0, 9'h03C, 1'b1);
    n1 = m_acc_cyc[0];
    send(0, 9'h05A, 1'b1);
    while (cyc < n1 + 47) @(negedge sys_clk);
    sys_rst = 1'b1;
    @(negedge sys_clk);
    check("abort_txd",   32'(txd[0]),  32'd1);
    check("abort_ready", 32'(rdy[0]),  32'd1);
    check("abort_busy",  32'(busy[0]), 32'd0);
    sys_rst = 1'b0;
    bad_cnt = 0;
    repeat (150) begin
      @(negedge sys_clk);
      if (done[0] || !txd[0]) bad_cnt++;
    end
    check("abort_no_frame", 32'(bad_cnt), 32'd0);

    // Random traffic with data churn and occasional resets.
    for (int c = 0; c < 3000; c++) begin
      for (int i = 0; i < 4; i++) begin
        if (vld[i]) begin
          if (m_acc[i]) begin
            if ($urandom_range(0, 1) == 0) vld[i] = 1'b0;
            dat[i] = 9'($urandom);
          end
        end else begin
          dat[i] = 9'($urandom);
          if ($urandom_range(0, 15) == 0) vld[i] = 1'b1;
        end
      end
      sys_rst = ($urandom_range(0, 1499) == 0);
      @(negedge sys_clk);
    end
    sys_rst = 1'b0;
    vld = '0;
    wait_quiet();

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule

// File: doc/uart_tx_cfg.md
UART_TX_CFG -- requirements
Module: uart_tx_cfg

Interface
REQ-001 Parameter CLK_FREQ, default 50000000, system clock frequency in Hz.
REQ-002 Parameter UART_BPS, default 9600, baud rate; BPS_CNT = CLK_FREQ / UART_BPS, integer division.
REQ-003 Parameter DATA_BITS, default 8, data bits per frame; legal range 5..9.
REQ-004 Parameter PARITY, default 0, parity mode: 0 none, 1 odd, 2 even.
REQ-005 Parameter STOP_BITS, default 1, stop bits per frame; legal values 1 or 2.
REQ-006 Port sys_clk, input, 1, the single clock; one clock; reset is synchronous and active-high.
REQ-007 Port sys_rst, input, 1, synchronous active-high reset.
REQ-008 Port tx_data, input, DATA_BITS, byte to send; sampled only on handshake.
REQ-009 Port tx_valid, input, 1, source has data on tx_data.
REQ-010 Port tx_ready, output, 1, holding register empty; a transfer occurs on a sys_clk edge with tx_valid and tx_ready both high.
REQ-011 Port uart_txd, output, 1, serial line; idle high.
REQ-012 Port tx_busy, output, 1, high while a frame is on the line (START through final STOP).
REQ-013 Port tx_done, output, 1, one-cycle pulse in the last cycle of the final stop bit.

Function
REQ-014 Frame order SHALL be: start bit (0), data LSB first, optional parity bit, STOP_BITS stop bits (1); each bit held exactly BPS_CNT cycles.
REQ-015 Parity SHALL be computed over the DATA_BITS latched bits: odd mode makes total ones (data+parity) odd; even mode makes it even.
REQ-016 FSM states SHALL be IDLE, START, DATA, PARITY, STOP; PARITY skipped when PARITY=0.
REQ-017 The block SHALL hold a one-entry holding register plus a shift register; tx_ready = holding register empty.
REQ-018 IDLE with holding register full SHALL move to START on the next cycle, transferring holding to shift register and freeing the holding register.
REQ-019 Latency: handshake at edge N with FSM idle SHALL drive uart_txd low from edge N+2.
REQ-020 A byte accepted during a frame SHALL start its start bit in the cycle immediately after the previous frame's last stop-bit cycle: zero idle gap.
REQ-021 Simultaneous handshake and holding-to-shift transfer in the same cycle SHALL be legal; the new byte lands in the holding register and tx_ready stays low.
REQ-022 The bit counter SHALL count DATA_BITS data bits and STOP_BITS stop bits, then return to 0; the baud counter is $clog2(BPS_CNT) bits wide and wraps at BPS_CNT-1.
REQ-023 The baud counter SHALL restart at 0 on every entry to START, never free-running across frames.
REQ-024 tx_data changes while tx_valid is low, or after handshake, SHALL NOT affect the line.
REQ-025 Illegal parameters (DATA_BITS outside 5..9, PARITY>2, STOP_BITS not 1/2, BPS_CNT<2) SHALL fail elaboration.

Reset
REQ-026 With sys_rst high at a sys_clk edge: uart_txd=1, tx_ready=1, tx_busy=0, tx_done=0, FSM=IDLE, counters=0, holding register empty.
REQ-027 Reset mid-frame SHALL abort immediately; the line goes high on the next edge and both the in-flight and buffered bytes are discarded.
REQ-028 uart_txd SHALL be registered; no glitch on reset release.

Structure
REQ-029 Package uart_pkg SHALL hold the FSM state typedef, parity mode constants (PAR_NONE/PAR_ODD/PAR_EVEN) and the BPS_CNT function.
REQ-030 Sub-module uart_baud_gen SHALL provide the baud counter and a bit_tick strobe, with a restart input.
REQ-031 Top-level RTL of 120-400 lines is expected; no other sub-modules.

Verification
REQ-032 Use CLK_FREQ=1000, UART_BPS=100 (BPS_CNT=10), 8N1: send 0xA5 -> line 0,1,0,1,0,0,1,0,1,1, each 10 cycles, tx_done at cycle 100 after start.
REQ-033 Set PARITY=2, DATA_BITS=7: send 0x55 -> parity bit 0; PARITY=1 -> parity bit 1; frame 100 cycles.
REQ-034 Back-to-back: send 0x00, then 0xFF accepted during the first frame -> second start bit immediately follows the first stop bit; tx_busy never drops.
REQ-035 Buffer full: hold tx_valid with three bytes -> tx_ready low after the second handshake until the first frame ends; all three bytes appear in order.
REQ-036 Assert sys_rst during data bit 3 of 0x3C -> uart_txd=1 next cycle, tx_ready=1, no tx_done, no further frame.
REQ-037 STOP_BITS=2: send 0x81 -> line high for 20 cycles after the data bits; tx_done on the 20th cycle.
